// File: rtl/isp_timing_gen.sv
// isp_timing_gen
//   Video timing and test-pattern source for the ISP pipeline. Free-running
//   h/v counters walk a parameterised raster. A small run/stop controller only
//   lets the generator stop at a frame boundary. Registered vsync/hsync/den
//   and 8-bit RGB form the transmitter end of the pipeline pixel interface.
//
//   Ports
//     clk          in   pixel clock
//     reset_n      in   asynchronous, active-low reset
//     enable       in   level; start/keep generating frames
//     pattern_sel  in   0 colour bars, 1 gradient, 2 checkerboard, 3 moving ramp
//     out_vsync    out  vertical sync, active high
//     out_hsync    out  horizontal sync, active high
//     out_den      out  data enable, high on active pixels
//     out_data_R/G/B out 8-bit colour, forced to 0 outside den
//     frame_start  out  one-clock pulse together with pixel (0,0)
//     busy         out  high whenever the controller is not idle
module isp_timing_gen #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 1024,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter int CHECK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       out_vsync,
  output logic       out_hsync,
  output logic       out_den,
  output logic [7:0] out_data_R,
  output logic [7:0] out_data_G,
  output logic [7:0] out_data_B,
  output logic       frame_start,
  output logic       busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are at least 8 bits wide because the gradient and ramp patterns
  // read bits [7:0], and wide enough for the checkerboard bit.
  localparam int HW0 = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int HW  = (HW0 > CHECK_LOG2) ? HW0 : CHECK_LOG2 + 1;
  localparam int VW0 = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
  localparam int VW  = (VW0 > CHECK_LOG2) ? VW0 : CHECK_LOG2 + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_W  = HW'(H_ACTIVE / 8);
  localparam logic [HW-1:0] H_ZERO = {HW{1'b0}};
  localparam logic [HW-1:0] H_ONE  = {{(HW-1){1'b0}}, 1'b1};

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_ZERO = {VW{1'b0}};
  localparam logic [VW-1:0] V_ONE  = {{(VW-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  // Stage 1: the raster position plus the pattern latched for the frame.
  // Output flops are fed from this stage, so pixel (0,0) can already see a
  // pattern latched at (0,0).
  logic          p_run_q, p_run_d;
  logic [HW-1:0] p_h_q, p_h_d;
  logic [VW-1:0] p_v_q, p_v_d;
  logic [7:0]    p_frame_q, p_frame_d;
  logic [1:0]    pat_q, pat_d;

  logic       vsync_d, hsync_d, den_d, fs_d, busy_d;
  logic [7:0] r_d, g_d, b_d;
  logic [7:0] r_s, g_s, b_s, ramp_s;
  logic [2:0] bar_s;
  logic       chk_s;
  logic       line_end_s, frame_end_s;

  assign line_end_s  = (h_cnt_q == H_LAST);
  assign frame_end_s = line_end_s && (v_cnt_q == V_LAST);

  // Run/stop controller: a stop request is deferred to the end of the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (enable)           state_d = ST_RUN;
        else if (frame_end_s) state_d = ST_IDLE;
        else                  state_d = ST_STOP;
      end
      ST_STOP: begin
        if (enable)           state_d = ST_RUN;
        else if (frame_end_s) state_d = ST_IDLE;
        else                  state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster counters; held at the origin while idle.
  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (state_q == ST_IDLE) begin
      h_cnt_d = H_ZERO;
      v_cnt_d = V_ZERO;
    end else if (line_end_s) begin
      h_cnt_d = H_ZERO;
      if (frame_end_s) begin
        v_cnt_d     = V_ZERO;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        v_cnt_d = v_cnt_q + V_ONE;
      end
    end else begin
      h_cnt_d = h_cnt_q + H_ONE;
    end
  end

  // Stage 1 capture; the pattern only changes at the frame origin.
  always_comb begin
    p_run_d   = (state_q != ST_IDLE);
    p_h_d     = h_cnt_q;
    p_v_d     = v_cnt_q;
    p_frame_d = frame_cnt_q;
    if ((state_q == ST_RUN) && (h_cnt_q == H_ZERO) && (v_cnt_q == V_ZERO)) begin
      pat_d = pattern_sel;
    end else begin
      pat_d = pat_q;
    end
  end

  // Pattern generation from the stage 1 position.
  always_comb begin
    bar_s  = 3'(p_h_q / BAR_W);
    ramp_s = p_h_q[7:0] + p_frame_q;
    chk_s  = p_h_q[CHECK_LOG2] ^ p_v_q[CHECK_LOG2];
    case (pat_q)
      2'd0: begin
        r_s = bar_s[1] ? 8'h00 : 8'hFF;
        g_s = bar_s[2] ? 8'h00 : 8'hFF;
        b_s = bar_s[0] ? 8'h00 : 8'hFF;
      end
      2'd1: begin
        r_s = p_h_q[7:0];
        g_s = p_v_q[7:0];
        b_s = 8'h80;
      end
      2'd2: begin
        r_s = chk_s ? 8'h00 : 8'hFF;
        g_s = r_s;
        b_s = r_s;
      end
      2'd3: begin
        r_s = ramp_s;
        g_s = ramp_s;
        b_s = ramp_s;
      end
      default: begin
        r_s = 8'h00;
        g_s = 8'h00;
        b_s = 8'h00;
      end
    endcase
  end

  // Output stage: sync/den decode and blanking of the colour channels.
  always_comb begin
    den_d   = p_run_q && (p_h_q < H_ACT) && (p_v_q < V_ACT);
    hsync_d = p_run_q && (p_h_q >= HS_BEG) && (p_h_q < HS_END);
    vsync_d = p_run_q && (p_v_q >= VS_BEG) && (p_v_q < VS_END);
    fs_d    = p_run_q && (p_h_q == H_ZERO) && (p_v_q == V_ZERO);
    busy_d  = (state_d != ST_IDLE);
    if (den_d) begin
      r_d = r_s;
      g_d = g_s;
      b_d = b_s;
    end else begin
      r_d = 8'h00;
      g_d = 8'h00;
      b_d = 8'h00;
    end
  end

  // All state and output flops; reset clears every output immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      h_cnt_q     <= H_ZERO;
      v_cnt_q     <= V_ZERO;
      frame_cnt_q <= 8'd0;
      p_run_q     <= 1'b0;
      p_h_q       <= H_ZERO;
      p_v_q       <= V_ZERO;
      p_frame_q   <= 8'd0;
      pat_q       <= 2'd0;
      out_vsync   <= 1'b0;
      out_hsync   <= 1'b0;
      out_den     <= 1'b0;
      out_data_R  <= 8'h00;
      out_data_G  <= 8'h00;
      out_data_B  <= 8'h00;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      p_run_q     <= p_run_d;
      p_h_q       <= p_h_d;
      p_v_q       <= p_v_d;
      p_frame_q   <= p_frame_d;
      pat_q       <= pat_d;
      out_vsync   <= vsync_d;
      out_hsync   <= hsync_d;
      out_den     <= den_d;
      out_data_R  <= r_d;
      out_data_G  <= g_d;
      out_data_B  <= b_d;
      frame_start <= fs_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_isp_timing_gen.sv
// Directed bench for isp_timing_gen on a 24x8 raster (16x4 active).
// Each output position p of a frame maps to h = p % 24, v = p / 24.
module tb_isp_timing_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       out_vsync, out_hsync, out_den, frame_start, busy;
  logic [7:0] out_data_R, out_data_G, out_data_B;

  int n_total = 0;
  int n_pass  = 0;
  int cur_pos = 0;
  int cur_fr  = 0;

  always #5 clk = ~clk;

  isp_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CHECK_LOG2(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
    .out_data_R(out_data_R), .out_data_G(out_data_G), .out_data_B(out_data_B),
    .frame_start(frame_start), .busy(busy)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s frame=%0d pos=%0d got %0h expected %0h", tag, cur_fr, cur_pos, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_den"},   24'(out_den), 24'd0);
    chk({tag, "_hsync"}, 24'(out_hsync), 24'd0);
    chk({tag, "_vsync"}, 24'(out_vsync), 24'd0);
    chk({tag, "_fs"},    24'(frame_start), 24'd0);
    chk({tag, "_rgb"},   {out_data_R, out_data_G, out_data_B}, 24'd0);
    chk({tag, "_busy"},  24'(busy), 24'd0);
  endtask

  function automatic logic [23:0] exp_rgb(input int pat, input int h, input int v, input int fr);
    logic [7:0] x;
    if (!(h < 16 && v < 4)) return 24'h000000;
    case (pat)
      0: case (h / 2)
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      1: return {8'(h), 8'(v), 8'h80};
      2: return ((((h / 2) ^ (v / 2)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
      default: begin
        x = 8'((h + fr) % 256);
        return {x, x, x};
      end
    endcase
  endfunction

  // Checks positions 0..npos-1 of one frame; applies input changes after the
  // check at the given positions (-1 = none).
  task automatic run_frame(input int pat, input int fr, input int npos,
                           input int off_at, input int on_at,
                           input int sel_at, input logic [1:0] sel_new,
                           input bit last);
    int h;
    int v;
    for (int p = 0; p < npos; p++) begin
      tick;
      cur_pos = p;
      cur_fr  = fr;
      h = p % 24;
      v = p / 24;
      chk("den",   24'(out_den),   24'(h < 16 && v < 4));
      chk("hsync", 24'(out_hsync), 24'(h >= 18 && h < 21));
      chk("vsync", 24'(out_vsync), 24'(v >= 5 && v < 7));
      chk("frame_start", 24'(frame_start), 24'(p == 0));
      chk("rgb", {out_data_R, out_data_G, out_data_B}, exp_rgb(pat, h, v, fr));
      chk("busy", 24'(busy), (last && p >= 190) ? 24'd0 : 24'd1);
      if (p == off_at) enable = 1'b0;
      if (p == on_at)  enable = 1'b1;
      if (p == sel_at) pattern_sel = sel_new;
    end
  endtask

  // Enable was just raised: one edge samples it, pixel (0,0) follows two edges later.
  task automatic start_latency(input string tag);
    tick;
    chk({tag, "_busy_n"}, 24'(busy), 24'd1);
    chk({tag, "_den_n"},  24'(out_den), 24'd0);
    tick;
    chk({tag, "_den_n1"}, 24'(out_den), 24'd0);
    chk({tag, "_fs_n1"},  24'(frame_start), 24'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) tick;
    chk_idle("reset");
    reset_n = 1'b1;
    tick;
    tick;
    chk_idle("idle");

    // Bars, switch to checkerboard mid-frame (takes effect next frame).
    enable = 1'b1;
    start_latency("start");
    run_frame(0, 0, 192, -1, -1, 50, 2'd2, 1'b0);
    run_frame(2, 1, 192, -1, -1, 10, 2'd1, 1'b0);
    run_frame(1, 2, 192, -1, -1, 10, 2'd3, 1'b0);
    run_frame(3, 3, 192, -1, -1, -1, 2'd0, 1'b0);

    // Stop mid-frame: the frame completes, then everything idles.
    run_frame(3, 4, 192, 100, -1, -1, 2'd0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      tick;
      cur_pos = 192 + i;
      chk_idle("stopped");
    end

    // Restart; stop then re-enable inside the same frame keeps frames continuous.
    enable = 1'b1;
    start_latency("restart");
    run_frame(3, 5, 192, 40, 120, -1, 2'd0, 1'b0);
    for (int f = 6; f < 258; f++) begin
      run_frame(3, f, 192, -1, -1, -1, 2'd0, 1'b0);
    end

    // Asynchronous reset in the middle of an active line.
    run_frame(3, 258, 30, -1, -1, -1, 2'd0, 1'b0);
    reset_n = 1'b0;
    enable  = 1'b0;
    #2;
    chk_idle("async_reset");
    tick;
    reset_n = 1'b1;
    tick;
    chk_idle("after_reset");

    // Ramp from a fresh frame counter: pixel h=5 reads 05, 06, 07.
    enable = 1'b1;
    start_latency("ramp");
    run_frame(3, 0, 192, -1, -1, -1, 2'd0, 1'b0);
    run_frame(3, 1, 192, -1, -1, -1, 2'd0, 1'b0);
    run_frame(3, 2, 192, -1, -1, -1, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
